// File: rtl/sr_flag_ctrl.sv
// sr_flag_ctrl: round-robin controller sharing a bank of SR flops between
// NREQ requesters. A request is granted in IDLE, drives a one-cycle S or R
// pulse to the addressed flop (DRIVE), reads back Q (CHECK), then pulses gnt.
//
// Ports:
//   clk, rst     clock, async active-high reset
//   req/op/idx   per-requester request, 1=set/0=clear, flag index
//                (requester i uses idx[i*FLAGW +: FLAGW])
//   q_in         Q readback from the flop bank
//   S/R          registered set/reset drives, at most one bit high
//   gnt          one-cycle one-hot completion pulse
//   busy         high while DRIVE or CHECK
//   err          sticky readback-mismatch flag
module sr_flag_ctrl #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int FLAGW = (NFLAG > 1) ? $clog2(NFLAG) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op,
  input  logic [NREQ*FLAGW-1:0] idx,
  input  logic [NFLAG-1:0]      q_in,
  output logic [NFLAG-1:0]      S,
  output logic [NFLAG-1:0]      R,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  err
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  typedef struct packed {
    logic [PTRW-1:0]  k;
    logic             op;
    logic [FLAGW-1:0] idx;
  } op_t;

  state_t           state, state_nx;
  op_t              cur, cur_nx;
  logic [PTRW-1:0]  ptr, ptr_nx;
  logic [NFLAG-1:0] s_nx, r_nx;
  logic [NREQ-1:0]  gnt_nx;
  logic             err_nx, busy_nx;

  logic             win_vld;
  logic [PTRW-1:0]  win;
  logic [FLAGW-1:0] sel_idx;
  logic [NFLAG-1:0] hit_sel, hit_cur;
  logic             q_sel, in_rng;

  // Round-robin: scan from ptr upward, first requester found wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && req[(int'(ptr) + i) % NREQ]) begin
        win_vld = 1'b1;
        win     = PTRW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign sel_idx = idx[int'(win)*FLAGW +: FLAGW];

  // Per-flag decode. An index past the bank matches no flop, so an
  // out-of-range request produces no pulse and skips the readback check.
  for (genvar f = 0; f < NFLAG; f++) begin : g_flag
    assign hit_sel[f] = (sel_idx == FLAGW'(f));
    assign hit_cur[f] = (cur.idx == FLAGW'(f));
  end

  assign q_sel  = |(q_in & hit_cur);
  assign in_rng = |hit_cur;

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    ptr_nx   = ptr;
    s_nx     = '0;
    r_nx     = '0;
    gnt_nx   = '0;
    err_nx   = err;
    case (state)
      IDLE: begin
        if (win_vld) begin
          cur_nx.k   = win;
          cur_nx.op  = op[win];
          cur_nx.idx = sel_idx;
          s_nx       = op[win] ? hit_sel : '0;
          r_nx       = op[win] ? '0 : hit_sel;
          state_nx   = DRIVE;
        end
      end
      DRIVE: state_nx = CHECK;
      CHECK: begin
        if (in_rng && (q_sel != cur.op)) err_nx = 1'b1;
        gnt_nx[cur.k] = 1'b1;
        ptr_nx   = (cur.k == PTRW'(NREQ-1)) ? '0 : cur.k + PTRW'(1);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      ptr   <= '0;
      S     <= '0;
      R     <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
      ptr   <= ptr_nx;
      S     <= s_nx;
      R     <= r_nx;
      gnt   <= gnt_nx;
      busy  <= busy_nx;
      err   <= err_nx;
    end
  end

endmodule
